// File: rtl/rom_addr_sequencer.sv
// ROM address sequencer: manual or rate-timed address stepping, load override,
// and registered capture of the returned ROM word with a valid pulse.
module rom_addr_sequencer #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter int RATE   = 4
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic              step,
  input  logic              dir,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_q,
  output logic              data_valid,
  output logic              wrap,
  output logic              busy,
  output logic [7:0]        step_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  localparam int              CNT_W    = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RATE - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0]    rate_cnt_q, rate_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                chg_q, chg_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;
  logic [7:0]          count_q, count_d;
  logic                step_pulse_s;
  logic                adv_s;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      rate_cnt_q <= '0;
      addr_q     <= '0;
      chg_q      <= 1'b0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= step;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      rate_cnt_q <= rate_cnt_d;
      addr_q     <= addr_d;
      chg_q      <= chg_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic for the run FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = mode ? AUTO : MANUAL;
        else       state_d = IDLE;
      end
      MANUAL: begin
        if (!start)    state_d = IDLE;
        else if (mode) state_d = AUTO;
        else           state_d = MANUAL;
      end
      AUTO: begin
        if (!start)     state_d = IDLE;
        else if (!mode) state_d = MANUAL;
        else            state_d = AUTO;
      end
      default: state_d = IDLE;
    endcase
  end

  // Advance decision, address arithmetic, rate counter and capture
  always_comb begin
    step_pulse_s = sync2_q & ~sync3_q;
    adv_s        = start & (((state_q == MANUAL) & step_pulse_s) |
                            ((state_q == AUTO) & (rate_cnt_q == CNT_MAX)));
    addr_d       = addr_q;
    rate_cnt_d   = '0;
    chg_d        = 1'b0;
    wrap_d       = 1'b0;
    count_d      = count_q;

    // Load wins over an advance in the same cycle and restarts the rate timer
    if (load) begin
      addr_d = load_addr;
      chg_d  = 1'b1;
    end else if (adv_s) begin
      chg_d = 1'b1;
      if (dir) begin
        addr_d = addr_q - ADDR_W'(1);
        wrap_d = (addr_q == '0);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        wrap_d = (addr_q == ADDR_MAX);
      end
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
      else                  count_d = count_q;
    end else begin
      addr_d = addr_q;
    end

    if (!load && (state_q == AUTO) && (state_d == AUTO)) begin
      if (rate_cnt_q == CNT_MAX) rate_cnt_d = '0;
      else                       rate_cnt_d = rate_cnt_q + CNT_W'(1);
    end else begin
      rate_cnt_d = '0;
    end

    // rom_data reflects the address updated on the previous edge
    if (chg_q) word_d = rom_data;
    else       word_d = word_q;
    valid_d = chg_q;
    busy_d  = (state_d != IDLE);
  end

  assign address    = addr_q;
  assign data_q     = word_q;
  assign data_valid = valid_q;
  assign wrap       = wrap_q;
  assign busy       = busy_q;
  assign step_count = count_q;

endmodule

// File: doc/rom_addr_sequencer.md
Name: rom_addr_sequencer

Overview:
Address sequencer that sits directly upstream of the 4-entry ROM lookup in top (address -> data_out) and drives its address, replacing the static SWI[3:2] mapping. It steps through the ROM in manual mode, one address per debounced-synchronised button press, or in auto mode at a programmable rate. It registers the returned ROM word so LED/LCD consumers get a stable value and a valid pulse.

Parameters:
ADDR_W, 2, ROM address width; the address wraps modulo 2^ADDR_W.
DATA_W, 4, ROM data width.
RATE, 4, clk_2 cycles per auto-mode advance; legal range >= 1.

Ports:
clk_2  input  1  sole clock; all state updates on its rising edge.
reset_n  input  1  synchronous, active-low reset.
start  input  1  level; 1 = run, 0 = idle.
mode  input  1  0 = manual, 1 = auto.
step  input  1  raw asynchronous button; 2-flop synchronised internally.
dir  input  1  0 = count up, 1 = count down.
load  input  1  level; loads load_addr.
load_addr  input  ADDR_W  value for load.
rom_data  input  DATA_W  combinational ROM output for the current address.
address  output  ADDR_W  ROM address.
data_q  output  DATA_W  registered ROM word.
data_valid  output  1  one-cycle pulse when data_q is updated.
wrap  output  1  one-cycle pulse on an address wrap-around.
busy  output  1  1 when state != IDLE.
step_count  output  8  number of advances; saturates at 255.

Behaviour:
- Reset (reset_n=0 at an edge): address=0, data_q=0, data_valid=0, wrap=0, busy=0, step_count=0, state=IDLE, sync flops=0, rate_cnt=0. A reset mid-operation discards any pending step edge or capture.
- FSM, transitions evaluated each edge:
  - IDLE: start=1 -> MANUAL if mode=0, AUTO if mode=1.
  - MANUAL/AUTO: start=0 -> IDLE, address retained.
  - mode toggle while running -> the other run state; rate_cnt cleared.
- Step synchroniser: sync1 <= step, sync2 <= sync1, sync3 <= sync2.
  - step_pulse = sync2 & ~sync3.
  - If step is first sampled high at edge E0, the address changes at edge E2.
  - Holding step high produces exactly one pulse.
- Advance conditions:
  - MANUAL: step_pulse.
  - AUTO: rate_cnt == RATE-1. rate_cnt counts 0..RATE-1 in AUTO and is held at 0 otherwise.
  - The first auto advance occurs RATE cycles after entering AUTO. RATE=1 advances every cycle.
  - Step pulses are ignored in IDLE and AUTO.
  - start=0 suppresses any advance in the same cycle.
- Advance arithmetic:
  - Up: address+1 mod 2^ADDR_W; wrap=1 for one cycle when going max -> 0.
  - Down: address-1 mod 2^ADDR_W; wrap=1 when going 0 -> max.
  - step_count += 1, saturating at 255.
- Load (load=1, any state including IDLE):
  - address <= load_addr; rate_cnt <= 0.
  - Load has priority over a simultaneous advance: no advance, no wrap, step_count unchanged.
- Capture: on the edge after any address change (advance or load), data_q <= rom_data (the word for the new address) and data_valid=1 for that cycle.
  - Back-to-back changes keep data_valid high continuously.
  - A load of the value already held still counts as a change and is captured.
- busy is registered from the state: 0 in IDLE, 1 in MANUAL and AUTO.

Test Plan:
- Reset, then manual step: reset_n=0 for 2 cycles, then start=1, mode=0, dir=0, step high for 10 cycles -> exactly one advance. address 0->1 two edges after step is first sampled; data_q=4'h6 and data_valid pulses on the next edge; step_count=1.
- Auto up with wrap, RATE=4, ROM {3,6,9,C}: start=1, mode=1 -> address 1,2,3,0 every 4 cycles. data_q follows 6,9,C,3. wrap pulses exactly once, at 3->0.
- Down direction: dir=1, auto, from address 0 -> address 3 with a wrap pulse and data_q=4'hC, then address 2 with data_q=4'h9.
- Load vs advance collision: load=1, load_addr=2 in the same cycle as an auto advance from address 0 -> address=2, no wrap, step_count unchanged, data_q=4'h9 one cycle later.
- Idle and mode switch: start=0 with step pulses -> address frozen, busy=0. Then start=1, mode=1, with mode toggled mid-count -> rate_cnt restarts and steps are ignored in AUTO.
- Reset mid-operation and saturation:
  - Assert reset_n=0 during AUTO at address 2 -> all outputs return to 0 at the next edge.
  - Run RATE=1 auto for 300 cycles -> step_count saturates at 255 and data_valid stays high.
